// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants and result type for the ripple-carry adder datapath.
package ripple_carry_adder_pkg;

    localparam int ADDER_WIDTH = 4;

    // Raw {carry, sum} result for the default-width adder.
    typedef logic [ADDER_WIDTH:0] adder_raw_t;

endpackage

// File: rtl/ripple_carry_adder_if.sv
// Operand/result bundle for the ripple-carry adder; master drives operands, slave returns the result.
interface ripple_carry_adder_if #(
    parameter int WIDTH = ripple_carry_adder_pkg::ADDER_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (output a, b, c_in, input sum, c_out);
    modport slave  (input a, b, c_in, output sum, c_out);
endinterface

// File: rtl/ripple_carry_adder_full_adder.sv
// 1-bit full-adder cell, one link of the carry chain.
// Latency: purely combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    logic p;

    assign p     = a ^ b;
    assign sum   = p ^ c_in;
    assign c_out = (a & b) | (c_in & p);
endmodule

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder with registered {c_out, sum}.
// Latency: 1 cycle from operands to result.
// Backpressure: none; accepts a new operand set every cycle.
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    ripple_carry_adder_if.slave  bus
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_d;
    logic             c_out_q;

    assign carry[0] = bus.c_in;

    // Explicit per-bit cells keep the carry path a true ripple from c_in to carry[WIDTH].
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a     (bus.a[i]),
            .b     (bus.b[i]),
            .c_in  (carry[i]),
            .sum   (s[i]),
            .c_out (carry[i+1])
        );
    end

    always_comb begin
        sum_d   = s;
        c_out_d = carry[WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench: WIDTH=4 table + exhaustive sweep, WIDTH=1 exhaustive, WIDTH=8 random.
module tb_ripple_carry_adder;
    import ripple_carry_adder_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    ripple_carry_adder_if #(.WIDTH(4)) i4 ();
    ripple_carry_adder_if #(.WIDTH(1)) i1 ();
    ripple_carry_adder_if #(.WIDTH(8)) i8 ();

    ripple_carry_adder #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(i4));
    ripple_carry_adder #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
    ripple_carry_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(i8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [3:0] s;
        logic       co;
        string      nm;
    } vec_t;

    vec_t tbl [6];

    // Expected results of the operands currently held in each output register.
    logic [8:0] prev4;
    logic [8:0] prev1;
    logic [8:0] prev8;

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] out4();
        return 9'({i4.c_out, i4.sum});
    endfunction
    function automatic logic [8:0] out1();
        return 9'({i1.c_out, i1.sum});
    endfunction
    function automatic logic [8:0] out8();
        return 9'({i8.c_out, i8.sum});
    endfunction

    // Called #1 after a rising edge: drive, confirm outputs hold until the edge, then check the new result.
    task automatic step(input logic [3:0] a4, input logic [3:0] b4, input logic c4,
                        input logic [8:0] exp4,
                        input logic a1, input logic b1, input logic c1,
                        input logic [7:0] a8, input logic [7:0] b8, input logic c8,
                        input string nm);
        int t1;
        int t8;
        logic [8:0] e1;
        logic [8:0] e8;
        t1 = int'(a1) + int'(b1) + int'(c1);
        t8 = int'(a8) + int'(b8) + int'(c8);
        e1 = 9'(t1);
        e8 = 9'(t8);
        i4.a = a4; i4.b = b4; i4.c_in = c4;
        i1.a = a1; i1.b = b1; i1.c_in = c1;
        i8.a = a8; i8.b = b8; i8.c_in = c8;
        #2;
        chk({nm, "_hold4"}, out4(), prev4);
        chk({nm, "_hold1"}, out1(), prev1);
        chk({nm, "_hold8"}, out8(), prev8);
        @(posedge clk);
        #1;
        chk({nm, "_w4"}, out4(), exp4);
        chk({nm, "_w1"}, out1(), e1);
        chk({nm, "_w8"}, out8(), e8);
        prev4 = exp4;
        prev1 = e1;
        prev8 = e8;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        tbl[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "zero"};
        tbl[1] = '{4'b0101, 4'b1011, 1'b1, 4'b0001, 1'b1, "5p11p1"};
        tbl[2] = '{4'b0111, 4'b1001, 1'b0, 4'b0000, 1'b1, "7p9"};
        tbl[3] = '{4'b0110, 4'b1100, 1'b1, 4'b0011, 1'b1, "6p12p1"};
        tbl[4] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, "ones_ones_1"};
        tbl[5] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, "ones_0_1"};

        // Reset held with nonzero operands present.
        rst = 1'b1;
        i4.a = 4'hF; i4.b = 4'hF; i4.c_in = 1'b1;
        i1.a = 1'b1; i1.b = 1'b1; i1.c_in = 1'b1;
        i8.a = 8'hFF; i8.b = 8'hFF; i8.c_in = 1'b1;
        prev4 = '0; prev1 = '0; prev8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w4", out4(), 9'd0);
        chk("rst_w1", out1(), 9'd0);
        chk("rst_w8", out8(), 9'd0);
        rst = 1'b0;

        // Directed table, back-to-back; W1/W8 ride along with fixed patterns.
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].a, tbl[i].b, tbl[i].c, 9'({tbl[i].co, tbl[i].s}),
                 tbl[i].a[0], tbl[i].b[0], tbl[i].c,
                 {tbl[i].a, tbl[i].b}, {tbl[i].b, tbl[i].a}, tbl[i].c, tbl[i].nm);
        end

        // Asynchronous reset in mid-cycle discards the in-flight result.
        i4.a = 4'h9; i4.b = 4'h8; i4.c_in = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_now_w4", out4(), 9'd0);
        chk("arst_now_w1", out1(), 9'd0);
        chk("arst_now_w8", out8(), 9'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_w4", out4(), 9'd0);
        chk("arst_hold_w8", out8(), 9'd0);
        rst = 1'b0;
        prev4 = '0; prev1 = '0; prev8 = '0;

        // Exhaustive W4 sweep (512 sets), W1 cycling all 8 sets, W8 random.
        for (int i = 0; i < 512; i++) begin
            logic [3:0] a4;
            logic [3:0] b4;
            logic       c4;
            adder_raw_t e4;
            a4 = 4'(i >> 5);
            b4 = 4'(i >> 1);
            c4 = 1'(i);
            e4 = adder_raw_t'({1'b0, a4} + {1'b0, b4} + {4'b0000, c4});
            step(a4, b4, c4, 9'(e4),
                 1'(i >> 2), 1'(i >> 1), 1'(i),
                 8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)),
                 "sweep");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ripple_carry_adder.md
Name: ripple_carry_adder

Overview:
- Parameterised binary adder: two WIDTH-bit operands plus a carry-in give a WIDTH-bit sum and a carry-out.
- The carry is formed by a chain of 1-bit full-adder cells, so it ripples from bit 0 up to bit WIDTH-1.
- The result is captured in an output register, giving a fixed one-cycle latency.
- Used as a datapath arithmetic primitive. Default configuration is a 4-bit adder.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range is 1 and above.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry into bit 0.
- sum  output  WIDTH  registered sum bits, (a + b + c_in) mod 2^WIDTH.
- c_out  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Arithmetic: {c_out, sum} = a + b + c_in, computed at WIDTH+1 bits. No truncation except that the MSB goes to c_out.
- Cell i (i = 0..WIDTH-1) computes:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
  - c[0] = c_in; c[WIDTH] drives the c_out register.
- The carry chain is purely combinational and built from explicit per-bit cells. No lookahead and no behavioural "+" on the full vector.
- Output register: on each rising clk edge with rst low, sum <= s and c_out <= c[WIDTH].
- Latency: inputs present before edge N appear on sum/c_out after edge N, i.e. exactly 1 cycle.
- Throughput: one new operand set per cycle; there is no handshake and no stall.
- Reset: while rst is high, sum = 0 and c_out = 0. Assertion takes effect immediately, independent of clk.
- First edge after rst deasserts: captures whatever inputs are present at that edge.
- Reset mid-operation: the in-flight result is discarded and outputs clear immediately. No partial result is ever visible.
- Boundaries:
  - all-ones + all-ones + 1 gives sum = all-ones, c_out = 1.
  - all-ones + 0 + 1 gives sum = 0, c_out = 1, i.e. a full ripple across all WIDTH bits.
  - 0 + 0 + 0 gives 0, 0.
- X on an input propagates only to the affected sum bits and the carries above them. No X-masking is required.
- Timing: the critical path is c_in → c[WIDTH], WIDTH cell delays. Synthesis must not restructure it into a prefix adder.

Decomposition:
- The shared package holds:
  - the default width constant ADDER_WIDTH = 4
  - a typedef for the WIDTH+1 bit raw result {carry, sum}.
- One sub-module, full_adder, with ports a, b, c_in → sum, c_out, purely combinational. It is instantiated WIDTH times via a generate loop, with the carry wired from cell i to cell i+1.
- The top level holds the generate chain plus the output register.

Test Plan:
- Reset: assert rst mid-cycle with prior nonzero outputs → sum = 0 and c_out = 0 immediately, without waiting for a clk edge; they stay 0 while rst is high.
- Default WIDTH=4, a=0000, b=0000, c_in=0 → after 1 edge sum=0000, c_out=0.
- a=0101, b=1011, c_in=1 (5+11+1=17) → after 1 edge sum=0001, c_out=1.
- a=0111, b=1001, c_in=0 (7+9=16) → after 1 edge sum=0000, c_out=1. Exercises full ripple with no c_in.
- a=0110, b=1100, c_in=1 (6+12+1=19) → sum=0011, c_out=1. Back-to-back with the previous vector, each result appears exactly one cycle after its inputs.
- Exhaustive sweep over all 512 combinations of a, b, c_in, for WIDTH=4 and for WIDTH=1 and WIDTH=8 (random), against a reference model → {c_out, sum} == a+b+c_in every cycle with 1-cycle latency.
